mb_r_bailout: RTL and testbench
===============================

# mb_r_bailout

Mandelbulb iteration stage directly upstream of the dr/zr stage. For every in-flight message it computes the radius r = sqrt(x_iter² + y_iter² + z_iter²) in fixed point and sets the bailout flag `threshold` when r exceeds the escape radius. It passes the rest of the message through unchanged, so the downstream dr/zr stage receives a valid `r` and `threshold` on the same beat. It is fully pipelined: one message accepted per clock, fixed latency, no backpressure.

## Interface
- `W`, default `$bits(fixedpoint::number)` (32): width of a fixed-point number, two's complement.
- `F`, default 16: fractional bits of `fixedpoint::number`.
- `BAILOUT`, default 32'h0002_0000 (2.0): escape radius, same format as `fixedpoint::number`.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `data_in` holds a message this cycle.
- `data_in`  in  `fixedpoint::message`  incoming message.
- `data_out`  out  `fixedpoint::message`  message with updated `r` and `threshold`. All-zero when `out_valid`=0.
- `out_valid`  out  1  `data_out` valid this cycle.

## Operation
- Stage S1 (squares): register signed products x·x, y·y, z·z. Each is 2W bits in Q(2F) format and non-negative.
- Stage S2 (sum): register the unsigned radicand s = sum of the three squares, 2W+2 bits wide, exact with no overflow.
- Stages Q0..QW (sqrt): non-restoring or restoring integer square root of s.
  - One root bit per stage, MSB first, W+1 stages.
  - Root is W+1 bits, floor(sqrt(s)), already in Q(F) format. No rounding.
- Stage O (output):
  - Saturation: if root ≥ 2^(W-1), r_new = {0, all ones} (maximum positive value); otherwise r_new = root[W-1:0].
  - If the incoming `threshold` = 1 (message already escaped): `r` and `threshold` pass through unchanged. The sqrt result is discarded.
  - Otherwise: `r` ← r_new and `threshold` ← (r_new > BAILOUT), signed and strictly greater. r == BAILOUT does not escape.
  - Every other field (pos, iter, dr, zr, theta, phi, steps, mem_addr, march_*, rayd_*, logdist, epsilon, mb_iter) is copied bit-exact from the matching input message.
- The message payload travels in a shift register alongside the arithmetic, with one valid bit per stage. Message order is preserved.
- Bubbles (`in_valid`=0) propagate as invalid slots. The pipeline advances every cycle regardless of `in_valid`.

## Timing
- Latency L = W+4 cycles (36 for W=32).
  - A message sampled with `in_valid`=1 at edge n appears with `out_valid`=1 after edge n+L.
- Throughput: 1 message/cycle. No ready signal; the consumer must accept every `out_valid` beat.
- `data_out` and `out_valid` are driven from registers, with `data_out` gated to zero when not valid. No combinational path from inputs.
- Reset (`rst_n`=0 at an edge):
  - Clears all stage valid bits.
  - `out_valid`=0 and `data_out`=0 from that edge until the first message accepted after release reaches the output.
- Reset mid-stream: all in-flight messages are dropped and never emitted. Data registers need not be cleared; only valid bits must be.
- `in_valid`=1 in the same cycle as `rst_n`=0: the message is dropped.
- Invalid slots never update `threshold` or `r` of neighbouring messages. Payload registers may load garbage when invalid.

## Test plan
- Basic value: x_iter=0x0001_0000, y=z=0, threshold=0 → after exactly 36 cycles r=0x0001_0000, threshold=0, all other fields unchanged.
- Escape and precision: x=y=z=0x0002_0000 → r=0x0003_76CF (floor of √12·65536), threshold=1.
  - Also x=0xFFFD_0000 (−3.0), y=z=0 → r=0x0003_0000, threshold=1.
- Bailout boundary: x=0x0002_0000, y=z=0 → r=0x0002_0000, threshold=0.
  - Also x=0x0002_0001 → threshold=1.
- Saturation and sticky flag:
  - x=y=z=0x8000_0000 → r=0x7FFF_FFFF, threshold=1.
  - Input threshold=1, r=0x1234_5678, x=0x0000_8000 → r=0x1234_5678, threshold=1 unchanged.
- Streaming: 40 back-to-back random messages, then 10 with `in_valid` toggling every cycle.
  - Outputs appear in order at latency 36, with bubble pattern preserved.
  - Every field matches a reference model bit-exact.
  - `data_out`=0 on every invalid cycle.
- Reset mid-stream: 20 consecutive messages, assert `rst_n`=0 for 1 cycle at cycle 10.
  - No output from messages accepted before or during reset.
  - `out_valid`=0 until a message injected after release emerges exactly 36 cycles later.

Source files
------------

// File: rtl/mb_r_bailout.sv
// Mandelbulb radius/bailout stage: r = floor(sqrt(x^2+y^2+z^2)) in Q(F), sets threshold when r > BAILOUT.
// Fixed latency W+4, one message per clock, message payload carried alongside the arithmetic.
package fixedpoint;
    typedef logic signed [31:0] number;

    typedef struct packed {
        number       pos_x;
        number       pos_y;
        number       pos_z;
        number       x_iter;
        number       y_iter;
        number       z_iter;
        number       dr;
        number       zr;
        number       r;
        number       theta;
        number       phi;
        logic        threshold;
        logic [15:0] steps;
        logic [15:0] mem_addr;
        number       march_dist;
        number       march_total;
        number       rayd_x;
        number       rayd_y;
        number       rayd_z;
        number       logdist;
        number       epsilon;
        logic [7:0]  mb_iter;
    } message;
endpackage

module mb_r_bailout
    import fixedpoint::*;
#(
    parameter int             W       = $bits(fixedpoint::number),
    parameter int             F       = 16,
    parameter logic [W-1:0]   BAILOUT = {{(W-2){1'b0}}, 2'b10} << F
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    input  message data_in,
    output message data_out,
    output logic   out_valid
);

    // Rank 0 captures the input, rank 1 squares, rank 2 sum, ranks 3..W+3 one root bit each.
    localparam int NP = W + 4;

    logic           vld_q  [0:NP-1];
    message         pl_q   [0:NP-1];
    logic [2*W-1:0] sq_x_q;
    logic [2*W-1:0] sq_y_q;
    logic [2*W-1:0] sq_z_q;
    logic [2*W+1:0] rad_q  [0:W];
    logic [W+1:0]   rem_q  [0:W];
    logic [W:0]     root_q [0:W+1];

    logic [2*W-1:0] sq_x_d;
    logic [2*W-1:0] sq_y_d;
    logic [2*W-1:0] sq_z_d;
    logic [2*W+1:0] rad_d;
    logic           ge_d   [0:W];
    logic [W+1:0]   rem_d  [1:W];
    logic [W:0]     root_d [1:W+1];
    logic [W:0]     root_fin_d;
    logic [W-1:0]   r_new_d;
    message         msg_d;
    message         data_out_d;
    message         data_out_q;
    logic           out_valid_q;

    // Signed squares and their exact unsigned sum.
    always_comb begin
        sq_x_d = $signed(pl_q[0].x_iter[W-1:0]) * $signed(pl_q[0].x_iter[W-1:0]);
        sq_y_d = $signed(pl_q[0].y_iter[W-1:0]) * $signed(pl_q[0].y_iter[W-1:0]);
        sq_z_d = $signed(pl_q[0].z_iter[W-1:0]) * $signed(pl_q[0].z_iter[W-1:0]);
        rad_d  = {2'b00, sq_x_q} + {2'b00, sq_y_q} + {2'b00, sq_z_q};
    end

    // Restoring square root: stage k brings down radicand pair W-k and decides one root bit.
    always_comb begin
        logic [W+3:0] sh_v;
        logic [W+3:0] tr_v;
        for (int k = 0; k <= W; k++) begin
            sh_v          = {rem_q[k], rad_q[k][2*(W-k)+1 -: 2]};
            tr_v          = {1'b0, root_q[k], 2'b01};
            ge_d[k]       = (sh_v >= tr_v);
            root_d[k+1]   = {root_q[k][W-1:0], ge_d[k]};
            if (k < W) begin
                if (ge_d[k]) begin
                    rem_d[k+1] = sh_v[W+1:0] - tr_v[W+1:0];
                end else begin
                    rem_d[k+1] = sh_v[W+1:0];
                end
            end else begin
                sh_v = sh_v;
            end
        end
    end

    // Saturate the root, apply bailout unless the message has already escaped, gate invalid beats.
    always_comb begin
        root_fin_d = root_q[W+1];
        if (|root_fin_d[W:W-1]) begin
            r_new_d = {1'b0, {(W-1){1'b1}}};
        end else begin
            r_new_d = root_fin_d[W-1:0];
        end
        msg_d = pl_q[NP-1];
        if (!pl_q[NP-1].threshold) begin
            msg_d.r         = r_new_d;
            msg_d.threshold = ($signed(r_new_d) > $signed(BAILOUT));
        end else begin
            msg_d.r         = pl_q[NP-1].r;
            msg_d.threshold = 1'b1;
        end
        if (vld_q[NP-1]) begin
            data_out_d = msg_d;
        end else begin
            data_out_d = '0;
        end
    end

    // Valid bits and output registers; the only state that reset must clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                vld_q[i] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < NP; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            out_valid_q <= vld_q[NP-1];
            data_out_q  <= data_out_d;
        end
    end

    // Payload and arithmetic datapath; free-running, never reset.
    always_ff @(posedge clk) begin
        pl_q[0] <= data_in;
        for (int i = 1; i < NP; i++) begin
            pl_q[i] <= pl_q[i-1];
        end
        sq_x_q    <= sq_x_d;
        sq_y_q    <= sq_y_d;
        sq_z_q    <= sq_z_d;
        rad_q[0]  <= rad_d;
        rem_q[0]  <= '0;
        root_q[0] <= '0;
        for (int k = 0; k < W; k++) begin
            rad_q[k+1] <= rad_q[k];
            rem_q[k+1] <= rem_d[k+1];
        end
        for (int k = 0; k <= W; k++) begin
            root_q[k+1] <= root_d[k+1];
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mb_r_bailout.sv
// Directed and streaming checks for mb_r_bailout against a trial-squaring reference model.
module tb_mb_r_bailout;
    import fixedpoint::*;

    localparam int MB  = $bits(message);
    localparam int LAT = 36;

    typedef struct {
        logic   v;
        message m;
    } ent_t;

    logic   clk;
    logic   rst_n;
    logic   in_valid;
    message data_in;
    message data_out;
    logic   out_valid;

    int     total;
    int     bad;
    ent_t   hist[$];

    mb_r_bailout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [67:0] sqr(input number x);
        longint a;
        a = longint'(x);
        return 68'(a * a);
    endfunction

    function automatic message model(input message m);
        logic [67:0] s;
        logic [67:0] t;
        logic [67:0] rt;
        number       rn;
        message      o;
        o = m;
        if (m.threshold) return o;
        s  = sqr(m.x_iter) + sqr(m.y_iter) + sqr(m.z_iter);
        rt = 68'd0;
        for (int b = 32; b >= 0; b--) begin
            t = rt | (68'd1 << b);
            if (t * t <= s) rt = t;
        end
        rn = (rt >= 68'h8000_0000) ? 32'h7FFF_FFFF : rt[31:0];
        o.r = rn;
        o.threshold = (rn > number'(32'h0002_0000));
        return o;
    endfunction

    function automatic message rand_msg();
        logic [MB-1:0] b;
        for (int i = 0; i < MB; i++) b[i] = 1'($urandom_range(0, 1));
        return message'(b);
    endfunction

    function automatic message rand_stream();
        message m;
        m = rand_msg();
        m.threshold = ($urandom_range(0, 3) == 0);
        m.x_iter = number'($signed($urandom) >>> $urandom_range(0, 15));
        m.y_iter = number'($signed($urandom) >>> $urandom_range(0, 15));
        m.z_iter = number'($signed($urandom) >>> $urandom_range(0, 15));
        return m;
    endfunction

    task automatic chk(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance, then compare the output with the entry injected LAT edges ago.
    task automatic step(input logic rst, input logic v, input message m);
        ent_t e;
        ent_t f;
        ent_t z;
        rst_n    = rst;
        in_valid = v;
        data_in  = m;
        @(posedge clk);
        #1;
        if (!rst) begin
            hist.delete();
            z.v = 1'b0;
            z.m = '0;
            repeat (LAT) hist.push_back(z);
        end
        e.v = v & rst;
        e.m = model(m);
        hist.push_back(e);
        if (hist.size() > LAT) begin
            f = hist.pop_front();
            chk("stream_valid", MB'(out_valid), MB'(f.v));
            chk("stream_data", data_out, f.v ? f.m : message'('0));
        end
    endtask

    task automatic run_dir(input string tag, input message m, input number er, input logic et);
        message e;
        e = m;
        e.r = er;
        e.threshold = et;
        step(1'b1, 1'b1, m);
        repeat (LAT) step(1'b1, 1'b0, rand_msg());
        chk({tag, "_valid"}, MB'(out_valid), MB'(1'b1));
        chk({tag, "_r"}, MB'(data_out.r), MB'(er));
        chk({tag, "_thr"}, MB'(data_out.threshold), MB'(et));
        chk({tag, "_msg"}, data_out, e);
    endtask

    initial begin
        message m;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;

        repeat (3) step(1'b0, 1'b1, rand_msg());
        chk("reset_valid", MB'(out_valid), MB'(1'b0));
        chk("reset_data", data_out, message'('0));

        m = rand_msg(); m.threshold = 1'b0;
        m.x_iter = 32'h0001_0000; m.y_iter = 32'h0; m.z_iter = 32'h0;
        run_dir("basic", m, 32'h0001_0000, 1'b0);

        m = rand_msg(); m.threshold = 1'b0;
        m.x_iter = 32'h0002_0000; m.y_iter = 32'h0002_0000; m.z_iter = 32'h0002_0000;
        run_dir("sqrt12", m, 32'h0003_76CF, 1'b1);

        m = rand_msg(); m.threshold = 1'b0;
        m.x_iter = 32'hFFFD_0000; m.y_iter = 32'h0; m.z_iter = 32'h0;
        run_dir("neg3", m, 32'h0003_0000, 1'b1);

        m = rand_msg(); m.threshold = 1'b0;
        m.x_iter = 32'h0002_0000; m.y_iter = 32'h0; m.z_iter = 32'h0;
        run_dir("at_bail", m, 32'h0002_0000, 1'b0);

        m = rand_msg(); m.threshold = 1'b0;
        m.x_iter = 32'h0002_0001; m.y_iter = 32'h0; m.z_iter = 32'h0;
        run_dir("over_bail", m, 32'h0002_0001, 1'b1);

        m = rand_msg(); m.threshold = 1'b0;
        m.x_iter = 32'h8000_0000; m.y_iter = 32'h8000_0000; m.z_iter = 32'h8000_0000;
        run_dir("saturate", m, 32'h7FFF_FFFF, 1'b1);

        m = rand_msg(); m.threshold = 1'b1; m.r = 32'h1234_5678;
        m.x_iter = 32'h0000_8000; m.y_iter = 32'h0; m.z_iter = 32'h0;
        run_dir("sticky", m, 32'h1234_5678, 1'b1);

        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, rand_stream());
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2) == 0, rand_stream());
        repeat (LAT + 4) step(1'b1, 1'b0, rand_msg());

        for (int i = 0; i < 20; i++) step((i == 10) ? 1'b0 : 1'b1, 1'b1, rand_stream());
        repeat (LAT + 4) step(1'b1, 1'b0, rand_msg());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
